// File: rtl/ika9958_cgen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// channel limits, default divisor width, run/stop state and half-period helper.
package ika9958_cgen_pkg;

   localparam int NCH_MAX = 8;
   localparam int DW_DEF  = 4;
   localparam int DW_MAX  = 16;

   typedef enum logic {
      CH_STOP = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   // High-phase length H = ceil(P/2) for a latched divisor dl (P = dl + 1).
   function automatic logic [DW_MAX:0] half_period(input logic [DW_MAX-1:0] dl);
      logic [DW_MAX:0] p;
      p = {1'b0, dl} + (DW_MAX + 1)'(1);
      return p - (p >> 1);
   endfunction

endpackage

// File: rtl/ika9958_cen_gen_ch.sv
// One divided-clock channel: phase counter, latched divisor, clock level,
// edge-enable pulses and sticky sync-alignment error flag.
module ika9958_cen_gen_ch
   import ika9958_cgen_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          i_XTAL1,
   input  logic          i_RST,
   input  logic          i_CEN,
   input  logic [DW-1:0] i_DIV,
   input  logic          i_SYNC_EV,
   input  logic          i_SYNC_EN,
   input  logic          i_ERR_CLR,
   output logic          o_CLK,
   output logic          o_PCEN,
   output logic          o_NCEN,
   output logic          o_ALIGN_ERR
);

   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dl_q,  dl_d;
   logic          clk_q, clk_d;
   logic          err_q, err_d;

   ch_state_e     state;
   logic [DW:0]   per;
   logic [DW:0]   half;
   logic [DW:0]   half_full_lo;
   logic [DW_MAX:0] half_full;
   logic [DW-1:0] cnt_inc;
   logic          div_nz;
   logic          at_top;
   logic          force_sync;
   logic          wrap;
   logic          align_set;

   assign state      = (dl_q != '0) ? CH_RUN : CH_STOP;
   assign per        = {1'b0, dl_q} + (DW + 1)'(1);
   assign half_full  = half_period(DW_MAX'(dl_q));
   assign half_full_lo = half_full[DW:0];
   assign half       = half_full_lo;
   assign cnt_inc    = cnt_q + DW'(1);
   assign div_nz     = (i_DIV != '0);
   assign at_top     = (cnt_q == dl_q);
   assign force_sync = i_SYNC_EV & i_SYNC_EN;
   assign wrap       = at_top | force_sync;
   // A sync edge landing anywhere except the natural wrap point means drift.
   assign align_set  = i_CEN & (state == CH_RUN) & force_sync & ~at_top;

   always_ff @(posedge i_XTAL1 or posedge i_RST) begin
      if (i_RST) begin
         cnt_q <= '0;
         dl_q  <= '0;
         clk_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dl_q  <= dl_d;
         clk_q <= clk_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      dl_d  = dl_q;
      clk_d = clk_q;
      err_d = err_q;
      if (i_CEN) begin
         case (state)
            CH_STOP: begin
               if (div_nz) begin
                  dl_d  = i_DIV;
                  cnt_d = '0;
                  clk_d = 1'b1;
               end
            end
            CH_RUN: begin
               if (wrap) begin
                  // Divisor is only sampled here, so a running period never gets cut short.
                  dl_d  = i_DIV;
                  cnt_d = '0;
                  clk_d = div_nz;
               end else begin
                  cnt_d = cnt_inc;
                  clk_d = ({1'b0, cnt_inc} < half);
               end
            end
            default: ;
         endcase
         if (align_set) begin
            err_d = 1'b1;
         end else if (i_ERR_CLR) begin
            err_d = 1'b0;
         end
      end
   end

   always_comb begin
      o_PCEN = 1'b0;
      o_NCEN = 1'b0;
      if (i_CEN && !i_RST) begin
         case (state)
            CH_STOP: o_PCEN = div_nz;
            CH_RUN: begin
               o_PCEN = wrap & div_nz;
               o_NCEN = ({1'b0, cnt_q} == (half - (DW + 1)'(1))) && (half < per);
            end
            default: ;
         endcase
      end
   end

   assign o_CLK       = clk_q;
   assign o_ALIGN_ERR = err_q;

endmodule

// File: rtl/ika9958_cen_gen.sv
// Multi-channel clock-enable generator: shared sync-edge detector feeding
// NCH independent divided-clock channels.
module ika9958_cen_gen
   import ika9958_cgen_pkg::*;
#(
   parameter int NCH = 3,
   parameter int DW  = DW_DEF
) (
   input  logic              i_XTAL1,
   input  logic              i_RST,
   input  logic              i_CEN,
   input  logic [NCH*DW-1:0] i_DIV,
   input  logic              i_SYNC_n,
   input  logic [NCH-1:0]    i_SYNC_MASK,
   input  logic              i_ERR_CLR,
   output logic [NCH-1:0]    o_CLK,
   output logic [NCH-1:0]    o_PCEN,
   output logic [NCH-1:0]    o_NCEN,
   output logic [NCH-1:0]    o_ALIGN_ERR
);

   logic sync_q;
   logic sync_d;
   logic sync_ev;

   always_ff @(posedge i_XTAL1 or posedge i_RST) begin
      if (i_RST) begin
         sync_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_d  = i_CEN ? i_SYNC_n : sync_q;
   // Falling edge of the master chip's clock, seen only on enabled cycles.
   assign sync_ev = i_CEN & sync_q & ~i_SYNC_n;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         ika9958_cen_gen_ch #(
            .DW (DW)
         ) u_ch (
            .i_XTAL1     (i_XTAL1),
            .i_RST       (i_RST),
            .i_CEN       (i_CEN),
            .i_DIV       (i_DIV[gi*DW +: DW]),
            .i_SYNC_EV   (sync_ev),
            .i_SYNC_EN   (i_SYNC_MASK[gi]),
            .i_ERR_CLR   (i_ERR_CLR),
            .o_CLK       (o_CLK[gi]),
            .o_PCEN      (o_PCEN[gi]),
            .o_NCEN      (o_NCEN[gi]),
            .o_ALIGN_ERR (o_ALIGN_ERR[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_ika9958_cen_gen.sv
// Self-checking bench for ika9958_cen_gen: directed literal scenarios plus a
// long randomized run, all checked every cycle against a period/phase model.
module tb_ika9958_cen_gen;

   localparam int NCH = 3;
   localparam int DW  = 4;

   logic              xtal = 1'b0;
   logic              rst;
   logic              cen;
   logic [NCH*DW-1:0] div;
   logic              sync_n;
   logic [NCH-1:0]    mask;
   logic              clr;
   logic [NCH-1:0]    o_clk, o_pcen, o_ncen, o_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: phase position within the period, latched period length, level, error.
   int   m_pos [NCH];
   int   m_per [NCH];
   bit   m_lvl [NCH];
   bit   m_err [NCH];
   bit   m_syncq;

   logic [NCH-1:0] last_pcen, last_ncen;

   always #5 xtal = ~xtal;

   ika9958_cen_gen #(.NCH(NCH), .DW(DW)) dut (
      .i_XTAL1     (xtal),
      .i_RST       (rst),
      .i_CEN       (cen),
      .i_DIV       (div),
      .i_SYNC_n    (sync_n),
      .i_SYNC_MASK (mask),
      .i_ERR_CLR   (clr),
      .o_CLK       (o_clk),
      .o_PCEN      (o_pcen),
      .o_NCEN      (o_ncen),
      .o_ALIGN_ERR (o_err)
   );

   task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_pos[k] = 0; m_per[k] = 0; m_lvl[k] = 0; m_err[k] = 0;
      end
      m_syncq = 1'b1;
   endtask

   function automatic int new_div(input int k);
      return int'(div[k*DW +: DW]);
   endfunction

   // A channel with period P >= 2 is high for the first ceil(P/2) positions.
   task automatic model_expect(output logic [NCH-1:0] ep, output logic [NCH-1:0] en,
                               output logic [NCH-1:0] ec, output logic [NCH-1:0] ee);
      bit sev;
      int hi;
      sev = cen && m_syncq && !sync_n;
      for (int k = 0; k < NCH; k++) begin
         ep[k] = 1'b0; en[k] = 1'b0;
         ec[k] = m_lvl[k]; ee[k] = m_err[k];
         if (cen && !rst) begin
            if (m_per[k] == 0) begin
               ep[k] = (new_div(k) != 0);
            end else begin
               hi = (m_per[k] + 1) / 2;
               ep[k] = (new_div(k) != 0) && (m_pos[k] == m_per[k] - 1 || (sev && mask[k]));
               en[k] = (m_pos[k] == hi - 1) && (hi < m_per[k]);
            end
         end
      end
   endtask

   task automatic model_step();
      bit sev;
      bit forced;
      int d;
      if (!cen) return;
      sev = m_syncq && !sync_n;
      for (int k = 0; k < NCH; k++) begin
         d = new_div(k);
         if (m_per[k] == 0) begin
            if (d != 0) begin
               m_per[k] = d + 1; m_pos[k] = 0; m_lvl[k] = 1;
            end
            if (clr) m_err[k] = 0;
         end else begin
            forced = sev && mask[k];
            if (forced && m_pos[k] != m_per[k] - 1) m_err[k] = 1;
            else if (clr) m_err[k] = 0;
            if (forced || m_pos[k] == m_per[k] - 1) begin
               m_pos[k] = 0;
               m_per[k] = (d == 0) ? 0 : d + 1;
               m_lvl[k] = (d != 0);
            end else begin
               m_pos[k] = m_pos[k] + 1;
               m_lvl[k] = (m_pos[k] < (m_per[k] + 1) / 2);
            end
         end
      end
      m_syncq = sync_n;
   endtask

   task automatic step(input logic c, input logic [NCH*DW-1:0] dv, input logic sn,
                       input logic [NCH-1:0] mk, input logic cl);
      logic [NCH-1:0] ep, en, ec, ee;
      @(negedge xtal);
      cen = c; div = dv; sync_n = sn; mask = mk; clr = cl;
      #2;
      model_expect(ep, en, ec, ee);
      chk("clk", o_clk, ec);
      chk("pcen", o_pcen, ep);
      chk("ncen", o_ncen, en);
      chk("align_err", o_err, ee);
      last_pcen = o_pcen;
      last_ncen = o_ncen;
      @(posedge xtal);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      @(negedge xtal);
      rst = 1'b1;
      #1;
      chk("rst_clk", o_clk, '0);
      chk("rst_pcen", o_pcen, '0);
      chk("rst_ncen", o_ncen, '0);
      chk("rst_err", o_err, '0);
      model_reset();
      @(posedge xtal);
      #1 rst = 1'b0;
   endtask

   localparam logic [NCH*DW-1:0] DIV_A = {4'd5, 4'd1, 4'd3};
   localparam logic [NCH*DW-1:0] DIV_S = {4'd0, 4'd0, 4'd3};

   initial begin
      logic [NCH-1:0] clk_tab [5];
      logic [NCH*DW-1:0] rdiv;
      logic [NCH-1:0] rmask;
      logic [NCH-1:0] rail;
      clk_tab[0] = 3'b111; clk_tab[1] = 3'b101; clk_tab[2] = 3'b110;
      clk_tab[3] = 3'b000; clk_tab[4] = 3'b011;

      rst = 1'b1; cen = 1'b0; div = '0; sync_n = 1'b1; mask = '0; clr = 1'b0;
      model_reset();
      repeat (2) @(posedge xtal);
      do_reset();

      // Divided clocks from reset: P = 4, 2, 6.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, DIV_A, 1'b1, '0, 1'b0);
         if (i == 0) chk("start_pcen", last_pcen, 3'b111);
         if (i == 1) chk("first_ncen", last_ncen, 3'b010);
         chk("clk_table", o_clk, clk_tab[i]);
      end
      for (int i = 0; i < 20; i++) step(1'b1, DIV_A, 1'b1, '0, 1'b0);
      // Divisor change mid-period, then every-other-cycle enable.
      for (int i = 0; i < 30; i++) step(1'b1, {4'd5, 4'd1, 4'd2}, 1'b1, '0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'(i & 1), {4'd3, 4'd3, 4'd3}, 1'b1, '0, 1'b0);

      // Sync realignment at ch0 cnt=1.
      do_reset();
      step(1'b1, DIV_S, 1'b1, 3'b001, 1'b0);
      step(1'b1, DIV_S, 1'b1, 3'b001, 1'b0);
      step(1'b1, DIV_S, 1'b0, 3'b001, 1'b0);
      chk("sync_pcen", last_pcen, 3'b001);
      chk("sync_clk", o_clk, 3'b001);
      chk("sync_err", o_err, 3'b001);
      for (int i = 0; i < 3; i++) step(1'b1, DIV_S, 1'b1, 3'b001, 1'b0);
      step(1'b1, DIV_S, 1'b0, 3'b001, 1'b0);
      chk("sync_wrap_pcen", last_pcen, 3'b001);
      chk("sync_wrap_err", o_err, 3'b001);
      step(1'b1, DIV_S, 1'b0, 3'b001, 1'b1);
      chk("err_clr", o_err, 3'b000);

      // Stop then restart.
      for (int i = 0; i < 6; i++) step(1'b1, '0, 1'b1, 3'b000, 1'b0);
      chk("stopped_clk", o_clk, 3'b000);
      step(1'b1, {4'd0, 4'd0, 4'd2}, 1'b1, 3'b000, 1'b0);
      chk("restart_pcen", last_pcen, 3'b001);
      chk("restart_clk", o_clk, 3'b001);

      // Randomized run.
      rdiv = DIV_A; rmask = '0; rail = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            for (int k = 0; k < NCH; k++)
               rdiv[k*DW +: DW] = ($urandom_range(0, 5) == 0) ? 4'd0 : DW'($urandom_range(1, 15));
         end
         if ($urandom_range(0, 49) == 0) rmask = NCH'($urandom);
         if ($urandom_range(0, 6) == 0) rail[0] = ~rail[0];
         if ($urandom_range(0, 799) == 0) do_reset();
         step(1'($urandom_range(0, 9) < 7), rdiv, rail[0], rmask,
              1'($urandom_range(0, 29) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
